// File: rtl/if_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: fetch FSM state
// encodings, the NOP word presented when no instruction is valid, and the
// sequential fetch stride.
package if_prefetch_queue_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifq_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instr} pairs for the prefetch
// queue. Flush empties the queue in one cycle and takes priority over any
// push or pop in that cycle. Head data is read combinationally.
module ifq_fifo #(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [DW-1:0]          wdata,
  output logic [DW-1:0]          rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage write; a write during flush is harmless since the pointers reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch front end: issues sequential fetches to a variable
// latency instruction memory, buffers up to DEPTH {pc, instr} pairs and
// hands the oldest to decode under a valid/stall handshake. Redirects flush
// the queue and restart fetch at the (word-aligned) target.
// Optional build macro IFQ_BYPASS_EN: a response arriving at an empty queue
// with decode ready is forwarded straight to the outputs the same cycle.
//
// state | meaning
// IDLE  | no request outstanding; issue one when the queue has room
// WAIT  | one request outstanding; its response owns a reserved slot
// DROP  | outstanding response belongs to a flushed path; discard it
module if_prefetch_queue
  import if_prefetch_queue_pkg::*;
#(
  parameter int              WIDTH    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             stall,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             valid_out,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ifq_state_t       state, state_nxt;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] req_pc;
  logic             push, fifo_pop, bypass;
  logic [CW-1:0]    fifo_count, cnt_after_pop;
  logic             fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] fifo_rdata;

  ifq_fifo #(.DW(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata ({req_pc, imem_rdata}),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state, request issue and queue push/pop decisions.
  always_comb begin
    state_nxt     = state;
    imem_req      = 1'b0;
    push          = 1'b0;
    bypass        = 1'b0;
    fifo_pop      = !fifo_empty && !stall;
    cnt_after_pop = fifo_count - CW'(fifo_pop);
    case (state)
      IDLE: begin
        if (!redirect && !(fifo_full && !fifo_pop)) begin
          imem_req  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          if (redirect) begin
            state_nxt = IDLE;
          end else begin
`ifdef IFQ_BYPASS_EN
            bypass = fifo_empty && !stall;
`endif
            push = !bypass;
            // Only issue again if the next response will also have a slot.
            if ((cnt_after_pop + CW'(push)) < DEPTH_C) imem_req = 1'b1;
            else                                       state_nxt = IDLE;
          end
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (imem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      push     = 1'b0;
      bypass   = 1'b0;
      fifo_pop = 1'b0;
    end
  end

  // Fetch address and the address of the request currently in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~WIDTH'(3);
    end else if (imem_req) begin
      fetch_pc <= fetch_pc + WIDTH'(PC_STEP);
      req_pc   <= fetch_pc;
    end
  end

  assign imem_addr = fetch_pc;
  assign valid_out = !fifo_empty || bypass;
  assign instr_out = bypass      ? imem_rdata :
                     !fifo_empty ? fifo_rdata[WIDTH-1:0] : WIDTH'(NOP_INSTR);
  assign pc_out    = bypass      ? req_pc :
                     !fifo_empty ? fifo_rdata[2*WIDTH-1:WIDTH] : '0;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue with a behavioural instruction memory
// of selectable latency. Instruction words are derived from the address so
// every {pc, instr} pair delivered to decode can be checked.
module tb_if_prefetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  int vectors = 0;
  int miscompares = 0;
  int lat = 1;

  if_prefetch_queue dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .valid_out  (valid_out),
    .instr_out  (instr_out),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h2002_004A;
  endfunction

  // Memory model: response lat cycles after the request cycle.
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [31:0] paddr = '0;
  always @(posedge clk) begin
    imem_ack <= 1'b0;
    if (rst) begin
      pend <= 1'b0;
    end else begin
      if (pend) begin
        if (cnt <= 1) begin
          imem_ack   <= 1'b1;
          imem_rdata <= instr_of(paddr);
          pend       <= 1'b0;
        end else begin
          cnt <= cnt - 1;
        end
      end
      if (imem_req) begin
        if (lat <= 1) begin
          imem_ack   <= 1'b1;
          imem_rdata <= instr_of(imem_addr);
        end else begin
          pend  <= 1'b1;
          cnt   <= lat - 1;
          paddr <= imem_addr;
        end
      end
    end
  end

  // Leaves the bench #1 into cycle c0, the first cycle with rst low.
  task automatic do_reset(input int l, input bit st);
    lat = l;
    rst = 1'b1;
    redirect = 1'b0;
    stall = st;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    redirect = 1'b0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (valid_out !== 1'b0 || instr_out !== 32'h0 || pc_out !== 32'h0 || imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b instr=%h pc=%h req=%b, expected 0/0/0/0",
               valid_out, instr_out, pc_out, imem_req);
    end
  endtask

  task automatic test_stream();
    int off;
    off = BYP ? 1 : 2;
    do_reset(1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) next_cycle();
      vectors++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin
        miscompares++;
        $display("FAIL stream_req[%0d]: req=%b addr=%h, expected req=1 addr=%h",
                 i, imem_req, imem_addr, 32'(4 * i));
      end
      vectors++;
      if (i < off) begin
        if (valid_out !== 1'b0) begin
          miscompares++;
          $display("FAIL stream_early_valid[%0d]: valid=%b, expected 0", i, valid_out);
        end
      end else if (valid_out !== 1'b1 || pc_out !== 32'(4 * (i - off)) ||
                   instr_out !== instr_of(32'(4 * (i - off)))) begin
        miscompares++;
        $display("FAIL stream_out[%0d]: valid=%b pc=%h instr=%h, expected 1 pc=%h instr=%h",
                 i, valid_out, pc_out, instr_out, 32'(4 * (i - off)),
                 instr_of(32'(4 * (i - off))));
      end
    end
  endtask

  task automatic test_stall();
    int reqs;
    reqs = 0;
    do_reset(1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) next_cycle();
      if (imem_req === 1'b1) reqs++;
      if (i >= 5) begin
        vectors++;
        if (imem_req !== 1'b0 || valid_out !== 1'b1 || pc_out !== 32'h0) begin
          miscompares++;
          $display("FAIL stall_hold[%0d]: req=%b valid=%b pc=%h, expected req=0 valid=1 pc=0",
                   i, imem_req, valid_out, pc_out);
        end
      end
    end
    vectors++;
    if (reqs != 4) begin
      miscompares++;
      $display("FAIL stall_req_count: %0d requests, expected 4", reqs);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stall = 1'b0;
      #1;
      vectors++;
      if (valid_out !== 1'b1 || pc_out !== 32'(4 * i) || instr_out !== instr_of(32'(4 * i))) begin
        miscompares++;
        $display("FAIL stall_drain[%0d]: valid=%b pc=%h instr=%h, expected 1 pc=%h instr=%h",
                 i, valid_out, pc_out, instr_out, 32'(4 * i), instr_of(32'(4 * i)));
      end
      if (i == 0) begin
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
          miscompares++;
          $display("FAIL stall_refill: req=%b addr=%h, expected req=1 addr=00000010",
                   imem_req, imem_addr);
        end
      end
    end
  endtask

  task automatic test_redirect_wait();
    do_reset(3, 1'b0);
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL rdw_first_req: req=%b addr=%h, expected req=1 addr=0", imem_req, imem_addr);
    end
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h103;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rdw_req_on_redirect: req=%b, expected 0", imem_req);
    end
    for (int c = 2; c <= 8; c++) begin
      @(negedge clk);
      redirect = 1'b0;
      #1;
      if (c <= 3) begin
        vectors++;
        if (imem_req !== 1'b0 || valid_out !== 1'b0) begin
          miscompares++;
          $display("FAIL rdw_drop[c%0d]: req=%b valid=%b, expected 0/0", c, imem_req, valid_out);
        end
      end else if (c == 4) begin
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || valid_out !== 1'b0) begin
          miscompares++;
          $display("FAIL rdw_refetch: req=%b addr=%h valid=%b, expected 1 addr=00000100 valid=0",
                   imem_req, imem_addr, valid_out);
        end
      end else if (c <= 6) begin
        vectors++;
        if (valid_out !== 1'b0) begin
          miscompares++;
          $display("FAIL rdw_wait[c%0d]: valid=%b, expected 0", c, valid_out);
        end
      end else begin
        vectors++;
        if ((c == 7) == BYP) begin
          if (valid_out !== 1'b1 || pc_out !== 32'h100 || instr_out !== instr_of(32'h100)) begin
            miscompares++;
            $display("FAIL rdw_target[c%0d]: valid=%b pc=%h instr=%h, expected 1 pc=00000100 instr=%h",
                     c, valid_out, pc_out, instr_out, instr_of(32'h100));
          end
        end else if (valid_out !== 1'b0) begin
          miscompares++;
          $display("FAIL rdw_target_idle[c%0d]: valid=%b, expected 0", c, valid_out);
        end
      end
    end
  endtask

  task automatic test_redirect_ack_pop();
    do_reset(1, 1'b0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    #1;
    vectors++;
    if (imem_req !== 1'b0 || imem_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL rap_coincident: req=%b ack=%b, expected req=0 ack=1", imem_req, imem_ack);
    end
    if (!BYP) begin
      vectors++;
      if (valid_out !== 1'b1 || pc_out !== 32'h4) begin
        miscompares++;
        $display("FAIL rap_pop_head: valid=%b pc=%h, expected 1 pc=00000004", valid_out, pc_out);
      end
    end
    @(negedge clk);
    redirect = 1'b0;
    #1;
    vectors++;
    if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL rap_flushed: valid=%b req=%b addr=%h, expected valid=0 req=1 addr=00000200",
               valid_out, imem_req, imem_addr);
    end
    next_cycle();
    vectors++;
    if (valid_out !== BYP || (BYP && pc_out !== 32'h200)) begin
      miscompares++;
      $display("FAIL rap_c5: valid=%b pc=%h, expected valid=%b pc=00000200", valid_out, pc_out, BYP);
    end
    next_cycle();
    vectors++;
    if (valid_out !== 1'b1 || pc_out !== (BYP ? 32'h204 : 32'h200)) begin
      miscompares++;
      $display("FAIL rap_c6: valid=%b pc=%h, expected valid=1 pc=%h",
               valid_out, pc_out, BYP ? 32'h204 : 32'h200);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(1, 1'b1);
    next_cycle();
    next_cycle();
    @(negedge clk);
    rst = 1'b1;
    #1;
    vectors++;
    if (valid_out !== 1'b1 || pc_out !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_before: valid=%b pc=%h, expected 1 pc=0", valid_out, pc_out);
    end
    next_cycle();
    vectors++;
    if (valid_out !== 1'b0 || imem_req !== 1'b0 || instr_out !== 32'h0) begin
      miscompares++;
      $display("FAIL rmid_cleared: valid=%b req=%b instr=%h, expected 0/0/0",
               valid_out, imem_req, instr_out);
    end
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_restart: req=%b addr=%h valid=%b, expected 1 addr=0 valid=0",
               imem_req, imem_addr, valid_out);
    end
    next_cycle();
    next_cycle();
    vectors++;
    if (valid_out !== 1'b1 || pc_out !== (BYP ? 32'h4 : 32'h0)) begin
      miscompares++;
      $display("FAIL rmid_first: valid=%b pc=%h, expected 1 pc=%h",
               valid_out, pc_out, BYP ? 32'h4 : 32'h0);
    end
  endtask

  task automatic test_bypass();
    do_reset(1, 1'b0);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 32'h40;
    #1;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    vectors++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || valid_out !== 1'b0) begin
      miscompares++;
      $display("FAIL byp_req: req=%b addr=%h valid=%b, expected 1 addr=00000040 valid=0",
               imem_req, imem_addr, valid_out);
    end
    next_cycle();
    vectors++;
    if (BYP) begin
      if (valid_out !== 1'b1 || instr_out !== 32'h2002000A || pc_out !== 32'h40) begin
        miscompares++;
        $display("FAIL byp_same_cycle: valid=%b instr=%h pc=%h, expected 1 instr=2002000a pc=00000040",
                 valid_out, instr_out, pc_out);
      end
    end else begin
      if (valid_out !== 1'b0 || instr_out !== 32'h0) begin
        miscompares++;
        $display("FAIL byp_off_ack_cycle: valid=%b instr=%h, expected 0/0", valid_out, instr_out);
      end
      next_cycle();
      vectors++;
      if (valid_out !== 1'b1 || instr_out !== 32'h2002000A || pc_out !== 32'h40) begin
        miscompares++;
        $display("FAIL byp_off_next: valid=%b instr=%h pc=%h, expected 1 instr=2002000a pc=00000040",
                 valid_out, instr_out, pc_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_reset_mid();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
